// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer
// Run/pause control and one-second timebase for the stopwatch counter chain.
// Turns single-cycle command pulses (start, stop, clear, lap) into a four-state
// machine, divides clk down to a one-cycle-per-second count enable, captures
// lap times from the live minutes/seconds and picks live or frozen time for
// the display. CLKS_PER_SEC must be 2 or more.
module stopwatch_sequencer #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  output logic       tick_en,
  output logic       clr,
  output logic [1:0] status,
  output logic [7:0] disp_minutes,
  output logic [5:0] disp_seconds,
  output logic [3:0] lap_count
);

  // The prescaler must be able to hold CLKS_PER_SEC-1.
  localparam int PW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);

  // The encoding is visible on the status port, so it is fixed here.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_LAP     = 2'b11
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic            r_clr;
  logic [7:0]      r_lap_min;
  logic [5:0]      r_lap_sec;
  logic [3:0]      r_lap_count;

  logic            w_counting;
  logic            w_tick;
  logic            w_capture;

  // The prescaler advances in both counting states; LAP keeps time running.
  assign w_counting = (r_state == ST_RUNNING) || (r_state == ST_LAP);

  // NOTE: tick is decoded purely from registers, so the enable to the seconds
  // counter is glitch-free and has no combinational path from the command pins.
  assign w_tick = w_counting && (r_presc == PRESC_MAX);

  // A lap is taken from RUNNING, or re-taken in LAP when no stronger command
  // (clear, stop, start) is present in the same cycle.
  assign w_capture = !clear && !stop && lap &&
                     ((r_state == ST_RUNNING) || ((r_state == ST_LAP) && !start));

  // State machine, prescaler, clear pulse and lap registers in one process.
  always_ff @(posedge clk) begin
    // NOTE: every state element here uses non-blocking assignment so all
    // registers update together from the values sampled on this edge.
    if (rst || clear) begin
      // Reset and clear behave alike: back to IDLE, partial second dropped,
      // laps forgotten, and a one-cycle clr so the counters zero as well.
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_clr       <= 1'b1;
      r_lap_min   <= '0;
      r_lap_sec   <= '0;
      r_lap_count <= '0;
    end else begin
      r_clr <= 1'b0;

      // Holds in PAUSED so a resume keeps the partial second; in IDLE it
      // was zeroed on entry and simply stays there.
      if (w_counting) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end

      unique case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_RUNNING;
        end
        ST_RUNNING: begin
          if (stop)     r_state <= ST_PAUSED;
          else if (lap) r_state <= ST_LAP;
        end
        ST_LAP: begin
          if (stop)       r_state <= ST_PAUSED;
          else if (start) r_state <= ST_RUNNING;
        end
        ST_PAUSED: begin
          if (start) r_state <= ST_RUNNING;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Live inputs are sampled before the counters see this cycle's tick,
      // so a capture coinciding with a tick records the pre-increment time.
      if (w_capture) begin
        r_lap_min <= minutes;
        r_lap_sec <= seconds;
        if (r_lap_count != 4'hF) r_lap_count <= r_lap_count + 4'd1;
      end
    end
  end

  assign tick_en      = w_tick;
  assign clr          = r_clr;
  assign status       = r_state;
  assign lap_count    = r_lap_count;
  assign disp_minutes = (r_state == ST_LAP) ? r_lap_min : minutes;
  assign disp_seconds = (r_state == ST_LAP) ? r_lap_sec : seconds;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb_stopwatch_sequencer
// Directed test-plan sequences followed by random command traffic. The
// stimulus side keeps a behavioural model (mode, running-cycle phase, list of
// captured laps, a seconds/minutes counter chain) and queues the expected
// outputs; a monitor on the falling edge pops and compares.
module tb_stopwatch_sequencer;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, lap;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic       tick_en, clr;
  logic [1:0] status;
  logic [7:0] disp_minutes;
  logic [5:0] disp_seconds;
  logic [3:0] lap_count;

  always #5 clk = ~clk;

  stopwatch_sequencer #(.CLKS_PER_SEC(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .lap          (lap),
    .minutes      (minutes),
    .seconds      (seconds),
    .tick_en      (tick_en),
    .clr          (clr),
    .status       (status),
    .disp_minutes (disp_minutes),
    .disp_seconds (disp_seconds),
    .lap_count    (lap_count)
  );

  typedef struct {
    logic [1:0] status;
    logic       tick;
    logic       clr;
    logic [7:0] dm;
    logic [5:0] ds;
    logic [3:0] lc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: mode uses the visible status codes 0 idle, 1 run, 2 pause, 3 lap.
  int          m_mode  = 0;
  int          m_phase = 0;    // counting cycles since last clear, modulo C
  bit          m_clr   = 1'b0; // clr pulse present in the current cycle
  logic [13:0] m_laps[$];      // every lap ever captured since last clear
  int          dp_min  = 0;    // live time presented to the DUT this cycle
  int          dp_sec  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic bit m_counting();
    return (m_mode == 1) || (m_mode == 3);
  endfunction

  // Drive one cycle of commands and queue what the outputs must be after it.
  task automatic cycle(input bit r, input bit st, input bit sp, input bit cl, input bit lp);
    bit   cur_tick;
    int   nmin, nsec;
    exp_t e;
    @(negedge clk); #1;
    rst = r; start = st; stop = sp; clear = cl; lap = lp;
    minutes = dp_min[7:0];
    seconds = dp_sec[5:0];
    cur_tick = m_counting() && (m_phase == C - 1);

    // Counter chain: zeroed by clr, otherwise advanced by the tick.
    nmin = dp_min; nsec = dp_sec;
    if (m_clr) begin
      nmin = 0; nsec = 0;
    end else if (cur_tick) begin
      if (nsec == 59) begin nsec = 0; nmin = (nmin + 1) % 256; end
      else nsec = nsec + 1;
    end

    if (r || cl) begin
      m_mode = 0; m_phase = 0; m_laps.delete(); m_clr = 1'b1;
    end else begin
      m_clr = 1'b0;
      if (m_counting()) m_phase = (m_phase + 1) % C;
      case (m_mode)
        0: if (st) m_mode = 1;
        1: if (sp) m_mode = 2;
           else if (lp) begin m_mode = 3; m_laps.push_back({dp_min[7:0], dp_sec[5:0]}); end
        3: if (sp) m_mode = 2;
           else if (st) m_mode = 1;
           else if (lp) m_laps.push_back({dp_min[7:0], dp_sec[5:0]});
        default: if (st) m_mode = 1;
      endcase
    end

    e.status = m_mode[1:0];
    e.tick   = m_counting() && (m_phase == C - 1);
    e.clr    = m_clr;
    if (m_mode == 3) {e.dm, e.ds} = m_laps[$];
    else begin e.dm = dp_min[7:0]; e.ds = dp_sec[5:0]; end
    e.lc = (m_laps.size() > 15) ? 4'd15 : 4'(m_laps.size());
    exp_q.push_back(e);

    dp_min = nmin; dp_sec = nsec;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every cycle for which an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("status",       32'(status),       32'(e.status));
        check("tick_en",      32'(tick_en),      32'(e.tick));
        check("clr",          32'(clr),          32'(e.clr));
        check("disp_minutes", 32'(disp_minutes), 32'(e.dm));
        check("disp_seconds", 32'(disp_seconds), 32'(e.ds));
        check("lap_count",    32'(lap_count),    32'(e.lc));
      end
    end
  end

  initial begin
    bit r, st, sp, cl, lp;
    int guard;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    minutes = '0; seconds = '0;

    // Reset, then start at cycle 0 and let three seconds elapse.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    idle(14);

    // Partial second survives a pause: clear, start, run, stop, wait, resume.
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    idle(1);
    cycle(0, 0, 1, 0, 0);
    idle(10);
    cycle(0, 1, 0, 0, 0);
    idle(6);

    // Lap at 1:05 freezes the display while live time moves on, then release.
    dp_min = 1; dp_sec = 5;
    cycle(0, 0, 0, 0, 1);
    idle(9);
    cycle(0, 1, 0, 0, 0);
    idle(3);

    // Coincident commands: stop+start -> PAUSED; clear+start -> IDLE.
    cycle(0, 1, 1, 0, 0);
    idle(1);
    cycle(0, 1, 0, 1, 0);
    idle(2);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 1, 0);
    idle(1);

    // Lap-count saturation: enter LAP then 17 more captures.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, 0, 1);
    idle(2);

    // Reset mid-LAP with the prescaler at 2, then a fresh start.
    guard = 0;
    while (m_phase != 2 && guard < 2 * C) begin idle(1); guard++; end
    check("reach_phase2", 32'(m_phase), 32'd2);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    idle(6);

    // Random command traffic.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      cl = ($urandom_range(0, 99) < 3);
      sp = ($urandom_range(0, 99) < 8);
      st = ($urandom_range(0, 99) < 10);
      lp = ($urandom_range(0, 99) < 12);
      if (st && lp && m_mode == 1) lp = 1'b0;
      if ($urandom_range(0, 99) < 5) begin
        dp_min = $urandom_range(0, 255);
        dp_sec = $urandom_range(0, 59);
      end
      cycle(r, st, sp, cl, lp);
    end
    cycle(0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
